ex_stage_mem_reg: RTL and testbench

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and applies forwarding muxes. Computes the ALU result, including an iterative multi-cycle multiply that stalls the upstream stages. Registers results and control for the MEM stage.

---
 rtl/ex_stage_mem_reg.sv | 218 +++++++++++++++++++++
 tb/tb_ex_stage_mem_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mem_reg.sv
// Execute stage with EX/MEM pipeline register: forwarding muxes, ALU, and an
// iterative shift-add multiplier that stalls upstream. Define FAST_MUL_EN for a single-cycle multiply.
module ex_stage_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ALUSrc,
  input  logic [3:0]        i_ALUop,
  input  logic              i_RegDst,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic              i_RegWrite,
  input  logic              i_MemToReg,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [REG_W-1:0]  i_rt,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [1:0]        i_fwd_a,
  input  logic [1:0]        i_fwd_b,
  input  logic [DATA_W-1:0] i_mem_fwd,
  input  logic [DATA_W-1:0] i_wb_fwd,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_MemRead,
  output logic              o_MemWrite,
  output logic              o_RegWrite,
  output logic              o_MemToReg,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_store_data,
  output logic [REG_W-1:0]  o_dst,
  output logic              o_zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [REG_W-1:0]  w_dst;
  logic              w_lt;

  always_comb begin
    case (i_fwd_a)
      2'b01:   w_op_a = i_wb_fwd;
      2'b10:   w_op_a = i_mem_fwd;
      default: w_op_a = i_data1;
    endcase
    case (i_fwd_b)
      2'b01:   w_fwd_b = i_wb_fwd;
      2'b10:   w_fwd_b = i_mem_fwd;
      default: w_fwd_b = i_data2;
    endcase
  end

  assign w_op_b = i_ALUSrc ? i_imm : w_fwd_b;
  assign w_dst  = i_RegDst ? i_rd : i_rt;
  assign w_lt   = $signed(w_op_a) < $signed(w_op_b);

  always_comb begin
    w_alu_res = '0;
    case (i_ALUop)
      OP_AND: w_alu_res = w_op_a & w_op_b;
      OP_OR:  w_alu_res = w_op_a | w_op_b;
      OP_ADD: w_alu_res = w_op_a + w_op_b;
      OP_SUB: w_alu_res = w_op_a - w_op_b;
      OP_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, w_lt};
      OP_NOR: w_alu_res = ~(w_op_a | w_op_b);
`ifdef FAST_MUL_EN
      OP_MUL: w_alu_res = w_op_a * w_op_b;
`endif
      default: w_alu_res = '0;
    endcase
  end

`ifdef FAST_MUL_EN

  assign o_stall = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_MemRead    <= 1'b0;
      o_MemWrite   <= 1'b0;
      o_RegWrite   <= 1'b0;
      o_MemToReg   <= 1'b0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_dst        <= '0;
      o_zero       <= 1'b0;
    end else if (i_flush) begin
      o_MemRead  <= 1'b0;
      o_MemWrite <= 1'b0;
      o_RegWrite <= 1'b0;
      o_MemToReg <= 1'b0;
    end else begin
      o_MemRead    <= i_MemRead;
      o_MemWrite   <= i_MemWrite;
      o_RegWrite   <= i_RegWrite;
      o_MemToReg   <= i_MemToReg;
      o_alu_result <= w_alu_res;
      o_store_data <= w_fwd_b;
      o_dst        <= w_dst;
      o_zero       <= (w_alu_res == '0);
    end
  end

`else

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_prod;
  logic [DATA_W-1:0] r_store;
  logic [REG_W-1:0]  r_dst;
  logic [3:0]        r_ctl;
  logic              w_is_mul;
  logic [DATA_W-1:0] w_prod_next;

  assign w_is_mul    = (i_ALUop == OP_MUL);
  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  // A flush during BUSY still stalls in that cycle; the stall drops once the FSM is back in IDLE.
  assign o_stall = rst &&
                   (((r_state == S_IDLE) && w_is_mul && !i_flush) || (r_state == S_BUSY));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_prod       <= '0;
      r_store      <= '0;
      r_dst        <= '0;
      r_ctl        <= '0;
      o_MemRead    <= 1'b0;
      o_MemWrite   <= 1'b0;
      o_RegWrite   <= 1'b0;
      o_MemToReg   <= 1'b0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_dst        <= '0;
      o_zero       <= 1'b0;
    end else if (i_flush) begin
      r_state    <= S_IDLE;
      o_MemRead  <= 1'b0;
      o_MemWrite <= 1'b0;
      o_RegWrite <= 1'b0;
      o_MemToReg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_mcand    <= w_op_a;
            r_mplier   <= w_op_b;
            r_prod     <= '0;
            r_store    <= w_fwd_b;
            r_dst      <= w_dst;
            r_ctl      <= {i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg};
            r_cnt      <= '0;
            r_state    <= S_BUSY;
            o_MemRead  <= 1'b0;
            o_MemWrite <= 1'b0;
            o_RegWrite <= 1'b0;
            o_MemToReg <= 1'b0;
          end else begin
            o_MemRead    <= i_MemRead;
            o_MemWrite   <= i_MemWrite;
            o_RegWrite   <= i_RegWrite;
            o_MemToReg   <= i_MemToReg;
            o_alu_result <= w_alu_res;
            o_store_data <= w_fwd_b;
            o_dst        <= w_dst;
            o_zero       <= (w_alu_res == '0);
          end
        end
        S_BUSY: begin
          r_prod     <= w_prod_next;
          r_mcand    <= r_mcand << 1;
          r_mplier   <= r_mplier >> 1;
          r_cnt      <= r_cnt + 1'b1;
          o_MemRead  <= 1'b0;
          o_MemWrite <= 1'b0;
          o_RegWrite <= 1'b0;
          o_MemToReg <= 1'b0;
          if (r_cnt == CNT_LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          {o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg} <= r_ctl;
          o_alu_result <= r_prod;
          o_store_data <= r_store;
          o_dst        <= r_dst;
          o_zero       <= (r_prod == '0);
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// Scoreboard bench for ex_stage_mem_reg: expected EX/MEM contents are queued when an
// instruction is driven and compared when the register loads it.
module tb_ex_stage_mem_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EXP_W  = 5 + REG_W + 2 * DATA_W;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_MUL = 4'b1000,
                         OP_NOR = 4'b1100;
`ifdef FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic              clk, rst;
  logic              i_ALUSrc, i_RegDst, i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg;
  logic [3:0]        i_ALUop;
  logic [DATA_W-1:0] i_data1, i_data2, i_imm, i_mem_fwd, i_wb_fwd;
  logic [REG_W-1:0]  i_rt, i_rd;
  logic [1:0]        i_fwd_a, i_fwd_b;
  logic              i_flush;
  logic              o_stall, o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg, o_zero;
  logic [DATA_W-1:0] o_alu_result, o_store_data;
  logic [REG_W-1:0]  o_dst;

  ex_stage_mem_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .i_ALUSrc(i_ALUSrc), .i_ALUop(i_ALUop), .i_RegDst(i_RegDst),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite),
    .i_MemToReg(i_MemToReg), .i_data1(i_data1), .i_data2(i_data2), .i_imm(i_imm),
    .i_rt(i_rt), .i_rd(i_rd), .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
    .i_mem_fwd(i_mem_fwd), .i_wb_fwd(i_wb_fwd), .i_flush(i_flush), .o_stall(o_stall),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_RegWrite(o_RegWrite),
    .o_MemToReg(o_MemToReg), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_dst(o_dst), .o_zero(o_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] m_result, m_store;
  logic [REG_W-1:0]  m_dst;
  logic              m_zero;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0] sel,
      input logic [DATA_W-1:0] rf, input logic [DATA_W-1:0] wb, input logic [DATA_W-1:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return rf;
  endfunction

  function automatic logic [DATA_W-1:0] alu_model(input logic [3:0] op,
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    case (op)
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_SLT: return (int'(a) < int'(b)) ? 1 : 0;
      OP_NOR: return ~(a | b);
      OP_MUL: return p[DATA_W-1:0];
      default: return '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_nop();
    i_ALUop = OP_AND; i_ALUSrc = 0; i_RegDst = 0;
    i_MemRead = 0; i_MemWrite = 0; i_RegWrite = 0; i_MemToReg = 0;
    i_data1 = '0; i_data2 = '0; i_imm = '0; i_rt = '0; i_rd = '0;
    i_fwd_a = 2'b00; i_fwd_b = 2'b00; i_mem_fwd = '0; i_wb_fwd = '0; i_flush = 0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic alusrc, input logic regdst,
      input logic [3:0] ctl, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
      input logic [DATA_W-1:0] imm, input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd,
      input logic [1:0] fa, input logic [1:0] fb,
      input logic [DATA_W-1:0] memf, input logic [DATA_W-1:0] wbf);
    i_ALUop = op; i_ALUSrc = alusrc; i_RegDst = regdst;
    {i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg} = ctl;
    i_data1 = d1; i_data2 = d2; i_imm = imm; i_rt = rt; i_rd = rd;
    i_fwd_a = fa; i_fwd_b = fb; i_mem_fwd = memf; i_wb_fwd = wbf; i_flush = 0;
  endtask

  // Issue one instruction, queue its expected EX/MEM contents, wait for the load and compare.
  task automatic run_op(input string tag, input logic [3:0] op, input logic alusrc,
      input logic regdst, input logic [3:0] ctl, input logic [DATA_W-1:0] d1,
      input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] imm,
      input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd, input logic [1:0] fa,
      input logic [1:0] fb, input logic [DATA_W-1:0] memf, input logic [DATA_W-1:0] wbf,
      input bit disturb);
    logic [DATA_W-1:0] a, fbv, b, res;
    logic [REG_W-1:0]  dst;
    logic [EXP_W-1:0]  e;
    int n, bad;
    a   = fwd_sel(fa, d1, wbf, memf);
    fbv = fwd_sel(fb, d2, wbf, memf);
    b   = alusrc ? imm : fbv;
    res = alu_model(op, a, b);
    dst = regdst ? rd : rt;
    exp_q.push_back({ctl, (res == '0), dst, fbv, res});
    m_result = res; m_store = fbv; m_dst = dst; m_zero = (res == '0);
    drive_op(op, alusrc, regdst, ctl, d1, d2, imm, rt, rd, fa, fb, memf, wbf);
    #1;
    if (op == OP_MUL && !FAST) begin
      n = 0; bad = 0;
      while (o_stall && n < 200) begin
        n++;
        if (disturb && n == 5) i_mem_fwd = ~memf;
        @(posedge clk); #1;
        if ({o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg} != 4'b0000) bad++;
      end
      check_eq({tag, "_stall_cycles"}, 64'(n), 64'(DATA_W + 1));
      check_eq({tag, "_bubble_ctl"}, 64'(bad), 64'd0);
    end else begin
      check_eq({tag, "_stall"}, {63'd0, o_stall}, 64'd0);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq({tag, "_result"}, 64'(o_alu_result), 64'(e[DATA_W-1:0]));
    check_eq({tag, "_store"}, 64'(o_store_data), 64'(e[2*DATA_W-1:DATA_W]));
    check_eq({tag, "_dst"}, 64'(o_dst), 64'(e[2*DATA_W+REG_W-1:2*DATA_W]));
    check_eq({tag, "_zero"}, {63'd0, o_zero}, {63'd0, e[2*DATA_W+REG_W]});
    check_eq({tag, "_ctl"}, 64'({o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg}),
             64'(e[EXP_W-1:EXP_W-4]));
  endtask

  task automatic check_held(input string tag);
    check_eq({tag, "_ctl"}, 64'({o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg}), 64'd0);
    check_eq({tag, "_result_held"}, 64'(o_alu_result), 64'(m_result));
    check_eq({tag, "_store_held"}, 64'(o_store_data), 64'(m_store));
    check_eq({tag, "_dst_held"}, 64'(o_dst), 64'(m_dst));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] op_tab[7];

  initial begin
    op_tab = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL};
    rst = 1'b0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_result", 64'(o_alu_result), 64'd0);
    check_eq("reset_store", 64'(o_store_data), 64'd0);
    check_eq("reset_dst", 64'(o_dst), 64'd0);
    check_eq("reset_flags", 64'({o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg, o_zero, o_stall}), 64'd0);
    m_result = '0; m_store = '0; m_dst = '0; m_zero = 1'b0;
    rst = 1'b1;

    run_op("add", OP_ADD, 0, 1, 4'b0010, 32'd5, 32'd7, 32'd0, 5'd9, 5'd3, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("sub_zero", OP_SUB, 0, 0, 4'b0010, 32'd9, 32'd9, 32'd0, 5'd4, 5'd8, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("slt_neg", OP_SLT, 0, 1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("slt_false", OP_SLT, 0, 1, 4'b0010, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("fwd_a_mem", OP_ADD, 1, 0, 4'b1001, 32'd1, 32'd0, 32'd4, 5'd6, 5'd7, 2'b10, 2'b00, 32'd100, 32'd0, 0);
    run_op("fwd_b_wb", OP_ADD, 1, 0, 4'b0100, 32'd2, 32'd55, 32'd8, 5'd11, 5'd0, 2'b00, 2'b01, 32'd0, 32'hAB, 0);
    run_op("fwd_11", OP_OR, 0, 1, 4'b0010, 32'hF0, 32'h0F, 32'd0, 5'd0, 5'd12, 2'b11, 2'b11, 32'd77, 32'd88, 0);
    run_op("add_wrap", OP_ADD, 0, 1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd13, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("bad_op", 4'b0011, 0, 1, 4'b0010, 32'd123, 32'd456, 32'd0, 5'd0, 5'd14, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("nor", OP_NOR, 0, 1, 4'b0010, 32'h1234_0000, 32'h0000_5678, 32'd0, 5'd0, 5'd15, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("mul_6x7", OP_MUL, 0, 1, 4'b0010, 32'd0, 32'd7, 32'd0, 5'd2, 5'd20, 2'b10, 2'b00, 32'd6, 32'd0, 1);
    run_op("mul_wrap", OP_MUL, 0, 1, 4'b0010, 32'h10000, 32'h10000, 32'd0, 5'd2, 5'd21, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("mul_b2b_1", OP_MUL, 0, 0, 4'b0110, $urandom, $urandom, 32'd0, 5'd22, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 0);
    run_op("mul_b2b_2", OP_MUL, 1, 1, 4'b0010, 32'hFFFF_FFFD, 32'd0, 32'd5, 5'd0, 5'd23, 2'b00, 2'b00, 32'd0, 32'd0, 0);

    // Flush of a single-cycle op: bubble, data outputs hold.
    drive_op(OP_ADD, 0, 1, 4'b0010, 32'd3, 32'd4, 32'd0, 5'd0, 5'd25, 2'b00, 2'b00, 32'd0, 32'd0);
    i_flush = 1'b1;
    #1;
    check_eq("flush_idle_stall", {63'd0, o_stall}, 64'd0);
    @(posedge clk); #1;
    check_held("flush_idle");
    set_nop();

`ifndef FAST_MUL_EN
    // Flush during the multiply.
    drive_op(OP_MUL, 0, 1, 4'b0010, 32'd11, 32'd13, 32'd0, 5'd0, 5'd26, 2'b00, 2'b00, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    #1;
    check_eq("flush_mul_stall_during", {63'd0, o_stall}, 64'd1);
    @(posedge clk); #1;
    set_nop();
    #1;
    check_eq("flush_mul_stall_after", {63'd0, o_stall}, 64'd0);
    check_held("flush_mul");

    // Reset during the multiply.
    drive_op(OP_MUL, 0, 1, 4'b0010, 32'd11, 32'd13, 32'd0, 5'd0, 5'd27, 2'b00, 2'b00, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mul_stall", {63'd0, o_stall}, 64'd0);
    check_eq("rst_mul_result", 64'(o_alu_result), 64'd0);
    check_eq("rst_mul_dst", 64'(o_dst), 64'd0);
    check_eq("rst_mul_flags", 64'({o_MemRead, o_MemWrite, o_RegWrite, o_MemToReg, o_zero}), 64'd0);
    set_nop();
    rst = 1'b1;
    m_result = '0; m_store = '0; m_dst = '0; m_zero = 1'b0;
`endif

    run_op("after_abort", OP_SUB, 0, 1, 4'b0010, 32'd50, 32'd8, 32'd0, 5'd0, 5'd28, 2'b00, 2'b00, 32'd0, 32'd0, 0);

    for (int k = 0; k < 10; k++) begin
      run_op("rand", op_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom, 0);
    end

    set_nop();
    repeat (2) @(posedge clk);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
